// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter.
//   state_e        : arbiter FSM states
//   REQ_CORE/AUX   : requester bit positions in the 2-bit request vectors
//   DEFAULT_*      : default operand and control-code widths
package alu_share_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned REQ_CORE      = 0;
    localparam int unsigned REQ_AUX       = 1;
    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CTL_W = 4;

endpackage

// File: rtl/alu_share_arb_operand_b_sel.sv
// Operand-B source select for one requester.
//   sel_i : 1 selects the immediate, 0 selects the register value
//   imm_i : immediate operand
//   reg_i : register-sourced operand
//   b_o   : selected operand B
module operand_b_sel #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [WIDTH-1:0] reg_i,
    output logic [WIDTH-1:0] b_o
);

    assign b_o = sel_i ? imm_i : reg_i;

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between a core datapath
// (bit 0) and an auxiliary unit (bit 1). One operation every three cycles:
// accept in IDLE, drive the ALU in EXEC, pulse the response in RESP.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake
//   req_a/req_reg/req_imm : packed per-requester operands (requester i at [i*WIDTH +: WIDTH])
//   req_alusrc            : per-requester operand-B select (1 = immediate)
//   req_ctl               : packed per-requester ALU control codes
//   alu_a/alu_b/alu_ctl   : operands to the shared ALU (zero while idle)
//   alu_result/alu_zero   : ALU outputs, combinational from alu_a/alu_b/alu_ctl
//   rsp_valid             : one-cycle pulse to the owning requester
//   rsp_result/rsp_zero   : captured ALU outputs, held until the next capture
//   busy                  : high whenever the FSM is not idle
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CTL_W = DEFAULT_CTL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_reg,
    input  logic [2*WIDTH-1:0] req_imm,
    input  logic [1:0]         req_alusrc,
    input  logic [2*CTL_W-1:0] req_ctl,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [CTL_W-1:0]   alu_ctl,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic [1:0]         rsp_valid,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero,
    output logic               busy
);

    state_e               state_q;
    logic                 last_q;   // requester granted most recently
    logic                 owner_q;  // requester owning the in-flight operation
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [CTL_W-1:0]     ctl_q;
    logic [1:0]           rsp_valid_q;
    logic [WIDTH-1:0]     rsp_result_q;
    logic                 rsp_zero_q;

    logic [1:0][WIDTH-1:0] b_sel;
    logic                  grant_idx;
    logic                  handshake;
    logic [WIDTH-1:0]      win_a;
    logic [WIDTH-1:0]      win_b;
    logic [CTL_W-1:0]      win_ctl;

    for (genvar i = 0; i < 2; i++) begin : g_b_sel
        operand_b_sel #(
            .WIDTH(WIDTH)
        ) u_operand_b_sel (
            .sel_i(req_alusrc[i]),
            .imm_i(req_imm[i*WIDTH +: WIDTH]),
            .reg_i(req_reg[i*WIDTH +: WIDTH]),
            .b_o  (b_sel[i])
        );
    end

    always_comb begin
        // Contention goes to whoever was not granted last; otherwise the lone
        // valid requester wins (bit 1 alone selects the auxiliary unit).
        if (req_valid == 2'b11) begin
            grant_idx = ~last_q;
        end else begin
            grant_idx = req_valid[REQ_AUX];
        end
        req_ready = '0;
        if ((state_q == StIdle) && !rst && (req_valid != 2'b00)) begin
            req_ready[grant_idx] = 1'b1;
        end
        handshake = |(req_valid & req_ready);
        win_a     = grant_idx ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
        win_b     = grant_idx ? b_sel[REQ_AUX]           : b_sel[REQ_CORE];
        win_ctl   = grant_idx ? req_ctl[2*CTL_W-1:CTL_W] : req_ctl[CTL_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;  // core wins the first contention
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            ctl_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        a_q     <= win_a;
                        b_q     <= win_b;
                        ctl_q   <= win_ctl;
                        owner_q <= grant_idx;
                        last_q  <= grant_idx;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero;
                    rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= StResp;
                end
                StResp: begin
                    rsp_valid_q <= '0;
                    state_q     <= StIdle;
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign busy       = (state_q != StIdle);
    assign alu_a      = busy ? a_q : '0;
    assign alu_b      = busy ? b_q : '0;
    assign alu_ctl    = busy ? ctl_q : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter CTL_W, default 4, ALU control code width.
REQ-003 Clocking: one clock, clk; reset rst, asynchronous, active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  2  per-requester request valid (bit0 = core datapath, bit1 = auxiliary unit).
REQ-007 req_ready  output  2  per-requester accept; handshake when valid&ready.
REQ-008 req_a  input  2xWIDTH  operand A per requester.
REQ-009 req_reg  input  2xWIDTH  register-sourced operand B per requester.
REQ-010 req_imm  input  2xWIDTH  immediate operand B per requester.
REQ-011 req_alusrc  input  2  per requester: 1 selects req_imm, 0 selects req_reg as operand B.
REQ-012 req_ctl  input  2xCTL_W  ALU control code per requester.
REQ-013 alu_a, alu_b  output  WIDTH  operands to the shared combinational ALU.
REQ-014 alu_ctl  output  CTL_W  control code to the ALU.
REQ-015 alu_result  input  WIDTH; alu_zero  input  1  ALU outputs, valid combinationally from alu_a/alu_b/alu_ctl.
REQ-016 rsp_valid  output  2  one-cycle pulse to the owning requester.
REQ-017 rsp_result  output  WIDTH; rsp_zero  output  1  captured ALU outputs.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, EXEC, RESP; IDLE->EXEC on handshake, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-020 req_ready is nonzero only in IDLE; at most one bit high, to the granted requester.
REQ-021 Grant in IDLE: single valid requester wins; both valid -> requester not granted last (round-robin pointer); pointer resets to favour bit0.
REQ-022 Pointer updates only on handshake.
REQ-023 On handshake, A, selected B (per alusrc) and ctl of the winner are latched; later input changes have no effect.
REQ-024 alu_a/alu_b/alu_ctl drive latched values in EXEC and RESP; zero in IDLE.
REQ-025 alu_result/alu_zero are registered into rsp_result/rsp_zero at the end of EXEC.
REQ-026 Latency: handshake in cycle N -> rsp_valid for the owner in cycle N+2, exactly one cycle; next accept earliest at N+3.
REQ-027 rsp_result/rsp_zero hold their value until the next capture.
REQ-028 A request with valid dropped before handshake is not serviced; no request is lost once accepted.
REQ-029 Throughput: one operation per 3 cycles; alternating grants when both requesters are continuously valid.

Reset
REQ-030 rst asserted in any state forces IDLE immediately; in-flight operation is discarded, no rsp_valid produced.
REQ-031 Reset values: req_ready=0 (combinational from IDLE, so grant logic resumes the cycle after rst deasserts), rsp_valid=0, rsp_result=0, rsp_zero=0, busy=0, alu_*=0, latches=0, pointer favours bit0.

Structure
REQ-032 Shared package holds: FSM state enum, requester index constants (REQ_CORE=0, REQ_AUX=1), default WIDTH/CTL_W.
REQ-033 One sub-module: operand_b_sel, a 2:1 WIDTH mux (select, immediate, register -> operand B), instantiated per requester ahead of the latch.

Verification
REQ-034 Reset mid-EXEC: req0 accepted (a=5,reg=3,ctl=ADD), rst asserted in EXEC -> no rsp_valid, state IDLE, all outputs 0.
REQ-035 Single req0, alusrc=1, a=10, imm=0xFFFFFFFE, ctl=ADD, accepted cycle N -> rsp_valid[0] at N+2, rsp_result=8, rsp_zero=0.
REQ-036 Single req1, alusrc=0, a=7, reg=7, ctl=SUB -> rsp_valid[1] two cycles after accept, rsp_result=0, rsp_zero=1.
REQ-037 Both valid continuously from reset -> grants 0,1,0,1 at cycles N, N+3, N+6, N+9; never both ready.
REQ-038 req0 changes a from 1 to 99 in EXEC -> result uses a=1.
REQ-039 req_valid asserted during EXEC/RESP -> req_ready=0 until IDLE; accepted at the first IDLE cycle.
